tft_cmd_parser: RTL and testbench

- Receive-side responder for the ASCII TFT command protocol carried on the UART link.
- Consumes bytes from the UART receiver, parses `TFT_C` and `TFT_L` command lines, and hands decoded commands to the TFT/SDRAM control path over a valid/ready handshake.
- Returns an `OK\r\n` or `ER\r\n` acknowledgement to the UART transmitter.
- Sits between `uart_rx`/`uart_tx` and the TFT controller inside `top`.

---
 rtl/tft_cmd_pkg.sv | 56 +++++
 rtl/tft_cmd_parser.sv | 229 ++++++++++++++++++++++
 tb/tb_tft_cmd_parser.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/tft_cmd_pkg.sv
// Shared definitions for the ASCII TFT command parser.
// Holds the command opcode encodings, the ASCII bytes of the protocol,
// the parser state enumeration and the character classification helpers.
package tft_cmd_pkg;

   typedef enum logic [1:0] {
      CMD_CLR     = 2'd0,
      CMD_CLR_IDX = 2'd1,
      CMD_LINE    = 2'd2
   } cmd_op_e;

   localparam logic [7:0] ASC_T     = 8'h54;
   localparam logic [7:0] ASC_F     = 8'h46;
   localparam logic [7:0] ASC_US    = 8'h5F;
   localparam logic [7:0] ASC_C     = 8'h43;
   localparam logic [7:0] ASC_L     = 8'h4C;
   localparam logic [7:0] ASC_COLON = 8'h3A;
   localparam logic [7:0] ASC_COMMA = 8'h2C;
   localparam logic [7:0] ASC_CR    = 8'h0D;
   localparam logic [7:0] ASC_LF    = 8'h0A;
   localparam logic [7:0] ASC_O     = 8'h4F;
   localparam logic [7:0] ASC_K     = 8'h4B;
   localparam logic [7:0] ASC_E     = 8'h45;
   localparam logic [7:0] ASC_R     = 8'h52;

   typedef enum logic [3:0] {
      S_IDLE,
      S_PREFIX,
      S_SEL,
      S_C_SEP,
      S_C_IDX,
      S_C_COMMA,
      S_C_COL,
      S_L_SEP,
      S_L_NUM,
      S_CR,
      S_LF,
      S_ISSUE,
      S_ACK,
      S_ERR_FLUSH
   } state_e;

   function automatic logic is_dec(input logic [7:0] b);
      return (b >= 8'h30) && (b <= 8'h39);
   endfunction

   // Uppercase hex only: 0-9, A-F.
   function automatic logic is_hex(input logic [7:0] b);
      return is_dec(b) || ((b >= 8'h41) && (b <= 8'h46));
   endfunction

   function automatic logic [3:0] hex2nib(input logic [7:0] b);
      return is_dec(b) ? b[3:0] : (b[3:0] + 4'd9);
   endfunction

endpackage

// File: rtl/tft_cmd_parser.sv
// Receive-side responder for the ASCII TFT command protocol.
// Parses TFT_C / TFT_C:H,HHHH / TFT_L:DDDDD lines from the UART receiver,
// presents the decoded command on a valid/ready handshake and answers each
// line with OK\r\n or ER\r\n towards the UART transmitter.
// Ports:
//   sys_clk, sys_nrst          clock, asynchronous active-low reset
//   rx_data, rx_valid          received byte and its one-cycle strobe
//   cmd_valid/cmd_ready        command handshake
//   cmd_op/idx/color/line      registered command fields
//   tx_data, tx_valid/tx_ready acknowledgement byte stream
//   rx_overrun                 sticky flag, set when a byte is dropped
module tft_cmd_parser
   import tft_cmd_pkg::*;
#(
   parameter int unsigned LINE_W  = 17,
   parameter bit          RESP_EN = 1'b1
) (
   input  logic              sys_clk,
   input  logic              sys_nrst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic [1:0]        cmd_op,
   output logic [3:0]        cmd_idx,
   output logic [15:0]       cmd_color,
   output logic [LINE_W-1:0] cmd_line,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              rx_overrun
);

   state_e              state, state_n;
   logic [2:0]          cnt, cnt_n;
   logic                err, err_n;
   cmd_op_e             op_q, op_n;
   logic [3:0]          idx_q, idx_n;
   logic [15:0]         col_q, col_n;
   logic [LINE_W-1:0]   line_q, line_n;
   logic [1:0]          cmd_op_n;
   logic [3:0]          cmd_idx_n;
   logic [15:0]         cmd_color_n;
   logic [LINE_W-1:0]   cmd_line_n;
   logic                ovr_n;
   logic                bad;
   logic [7:0]          pre_ch;
   logic [3:0]          nib;

   always_ff @(posedge sys_clk or negedge sys_nrst) begin
      if (!sys_nrst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         err        <= 1'b0;
         op_q       <= CMD_CLR;
         idx_q      <= '0;
         col_q      <= '0;
         line_q     <= '0;
         cmd_op     <= '0;
         cmd_idx    <= '0;
         cmd_color  <= '0;
         cmd_line   <= '0;
         rx_overrun <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         err        <= err_n;
         op_q       <= op_n;
         idx_q      <= idx_n;
         col_q      <= col_n;
         line_q     <= line_n;
         cmd_op     <= cmd_op_n;
         cmd_idx    <= cmd_idx_n;
         cmd_color  <= cmd_color_n;
         cmd_line   <= cmd_line_n;
         rx_overrun <= ovr_n;
      end
   end

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      err_n       = err;
      op_n        = op_q;
      idx_n       = idx_q;
      col_n       = col_q;
      line_n      = line_q;
      cmd_op_n    = cmd_op;
      cmd_idx_n   = cmd_idx;
      cmd_color_n = cmd_color;
      cmd_line_n  = cmd_line;
      ovr_n       = rx_overrun;
      bad         = 1'b0;
      nib         = hex2nib(rx_data);
      pre_ch      = (cnt == 3'd0) ? ASC_F : ((cnt == 3'd1) ? ASC_T : ASC_US);

      case (state)
         S_IDLE: if (rx_valid) begin
            if (rx_data == ASC_T) begin
               state_n = S_PREFIX;
               cnt_n   = '0;
               op_n    = CMD_CLR;
               idx_n   = '0;
               col_n   = '0;
               line_n  = '0;
            end else bad = 1'b1;
         end
         S_PREFIX: if (rx_valid) begin
            if (rx_data == pre_ch) begin
               cnt_n = cnt + 3'd1;
               if (cnt == 3'd2) state_n = S_SEL;
            end else bad = 1'b1;
         end
         S_SEL: if (rx_valid) begin
            if (rx_data == ASC_C) begin
               state_n = S_C_SEP;
               op_n    = CMD_CLR;
            end else if (rx_data == ASC_L) begin
               state_n = S_L_SEP;
               op_n    = CMD_LINE;
            end else bad = 1'b1;
         end
         S_C_SEP: if (rx_valid) begin
            if (rx_data == ASC_CR) state_n = S_LF;
            else if (rx_data == ASC_COLON) begin
               state_n = S_C_IDX;
               op_n    = CMD_CLR_IDX;
            end else bad = 1'b1;
         end
         S_C_IDX: if (rx_valid) begin
            if (is_hex(rx_data)) begin
               idx_n   = nib;
               state_n = S_C_COMMA;
            end else bad = 1'b1;
         end
         S_C_COMMA: if (rx_valid) begin
            if (rx_data == ASC_COMMA) begin
               state_n = S_C_COL;
               cnt_n   = '0;
            end else bad = 1'b1;
         end
         S_C_COL: if (rx_valid) begin
            if (is_hex(rx_data)) begin
               col_n = {col_q[11:0], nib};
               cnt_n = cnt + 3'd1;
               if (cnt == 3'd3) state_n = S_CR;
            end else bad = 1'b1;
         end
         S_L_SEP: if (rx_valid) begin
            if (rx_data == ASC_COLON) begin
               state_n = S_L_NUM;
               cnt_n   = '0;
            end else bad = 1'b1;
         end
         S_L_NUM: if (rx_valid) begin
            if (is_dec(rx_data)) begin
               // acc*10 as (acc<<3)+(acc<<1)
               line_n = (line_q << 3) + (line_q << 1) + LINE_W'(rx_data[3:0]);
               cnt_n  = cnt + 3'd1;
               if (cnt == 3'd4) state_n = S_CR;
            end else bad = 1'b1;
         end
         S_CR: if (rx_valid) begin
            if (rx_data == ASC_CR) state_n = S_LF;
            else bad = 1'b1;
         end
         S_LF: if (rx_valid) begin
            if (rx_data == ASC_LF) begin
               state_n     = S_ISSUE;
               cmd_op_n    = op_q;
               cmd_idx_n   = idx_q;
               cmd_color_n = col_q;
               cmd_line_n  = line_q;
            end else bad = 1'b1;
         end
         S_ISSUE: begin
            if (rx_valid) ovr_n = 1'b1;
            if (cmd_ready) begin
               err_n   = 1'b0;
               cnt_n   = '0;
               state_n = RESP_EN ? S_ACK : S_IDLE;
            end
         end
         S_ACK: begin
            if (rx_valid) ovr_n = 1'b1;
            if (tx_ready) begin
               cnt_n = cnt + 3'd1;
               if (cnt == 3'd3) begin
                  cnt_n   = '0;
                  state_n = S_IDLE;
               end
            end
         end
         S_ERR_FLUSH: if (rx_valid && (rx_data == ASC_LF)) begin
            err_n   = 1'b1;
            cnt_n   = '0;
            state_n = RESP_EN ? S_ACK : S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase

      // A stray LF already terminates the line, so it is answered directly.
      if (bad) begin
         if (rx_data == ASC_LF) begin
            err_n   = 1'b1;
            cnt_n   = '0;
            state_n = RESP_EN ? S_ACK : S_IDLE;
         end else begin
            state_n = S_ERR_FLUSH;
         end
      end
   end

   assign cmd_valid = (state == S_ISSUE);
   assign tx_valid  = (state == S_ACK);

   always_comb begin
      tx_data = '0;
      if (state == S_ACK) begin
         case (cnt[1:0])
            2'd0:    tx_data = err ? ASC_E : ASC_O;
            2'd1:    tx_data = err ? ASC_R : ASC_K;
            2'd2:    tx_data = ASC_CR;
            default: tx_data = ASC_LF;
         endcase
      end
   end

endmodule

// File: tb/tb_tft_cmd_parser.sv
// Directed self-checking bench for tft_cmd_parser.
module tb_tft_cmd_parser;

   logic        clk;
   logic        nrst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [3:0]  cmd_idx;
   logic [15:0] cmd_color;
   logic [16:0] cmd_line;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        rx_overrun;

   int errors = 0;
   int checks = 0;
   int hs_cnt = 0;
   int tx_hs  = 0;
   int base_hs, base_tx;

   tft_cmd_parser #(.LINE_W(17), .RESP_EN(1'b1)) dut (
      .sys_clk(clk), .sys_nrst(nrst),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_idx(cmd_idx), .cmd_color(cmd_color), .cmd_line(cmd_line),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_overrun(rx_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (nrst && cmd_valid && cmd_ready) hs_cnt++;
      if (nrst && tx_valid && tx_ready) tx_hs++;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // All drive tasks start and end on a falling edge.
   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic send_line(input string s);
      send_str(s);
      send_byte(8'h0D);
      send_byte(8'h0A);
   endtask

   task automatic ack_expect(input string tag, input logic [7:0] b0, input logic [7:0] b1);
      logic [7:0] exp [4];
      int w;
      exp[0] = b0; exp[1] = b1; exp[2] = 8'h0D; exp[3] = 8'h0A;
      w = 0;
      while (!tx_valid && w < 20) begin
         @(negedge clk);
         w++;
      end
      for (int i = 0; i < 4; i++) begin
         chk({tag, "_txv"}, tx_valid, 1);
         chk({tag, "_txd"}, tx_data, exp[i]);
         @(negedge clk);
      end
      chk({tag, "_txend"}, tx_valid, 0);
   endtask

   // Expects to be called on the falling edge right after the LF strobe.
   task automatic check_cmd(input string tag, input logic [1:0] op, input logic [3:0] idx,
                            input logic [15:0] col, input logic [16:0] line, input bit is_line);
      chk({tag, "_valid"}, cmd_valid, 1);
      chk({tag, "_op"}, cmd_op, op);
      if (is_line) chk({tag, "_line"}, cmd_line, line);
      else begin
         chk({tag, "_idx"}, cmd_idx, idx);
         chk({tag, "_col"}, cmd_color, col);
      end
      @(negedge clk);
      chk({tag, "_vfall"}, cmd_valid, 0);
      ack_expect(tag, 8'h4F, 8'h4B);
   endtask

   task automatic err_case(input string tag, input string s, input bit bare_lf);
      base_hs = hs_cnt;
      base_tx = tx_hs;
      if (bare_lf) send_byte(8'h0A);
      else send_line(s);
      ack_expect(tag, 8'h45, 8'h52);
      repeat (3) @(negedge clk);
      chk({tag, "_nocmd"}, hs_cnt - base_hs, 0);
      chk({tag, "_txcount"}, tx_hs - base_tx, 4);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_cmdv"}, cmd_valid, 0);
      chk({tag, "_op"}, cmd_op, 0);
      chk({tag, "_idx"}, cmd_idx, 0);
      chk({tag, "_col"}, cmd_color, 0);
      chk({tag, "_line"}, cmd_line, 0);
      chk({tag, "_txv"}, tx_valid, 0);
      chk({tag, "_txd"}, tx_data, 0);
      chk({tag, "_ovr"}, rx_overrun, 0);
   endtask

   initial begin
      nrst = 1'b0; rx_data = '0; rx_valid = 1'b0; cmd_ready = 1'b1; tx_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_vals("rst");
      nrst = 1'b1;
      @(negedge clk);

      // 1: default clear
      send_line("TFT_C");
      check_cmd("clr", 2'd0, 4'h0, 16'h0000, 17'd0, 1'b0);

      // 2: indexed clears
      send_line("TFT_C:A,2C1F");
      check_cmd("clrA", 2'd1, 4'hA, 16'h2C1F, 17'd0, 1'b0);
      send_line("TFT_C:4,DE72");
      check_cmd("clr4", 2'd1, 4'h4, 16'hDE72, 17'd0, 1'b0);

      // 3: line commands, second one with back-pressure
      send_line("TFT_L:00007");
      check_cmd("line7", 2'd2, 4'h0, 16'h0, 17'd7, 1'b1);
      cmd_ready = 1'b0;
      send_line("TFT_L:99999");
      for (int i = 0; i < 10; i++) begin
         chk("hold_valid", cmd_valid, 1);
         chk("hold_op", cmd_op, 2);
         chk("hold_line", cmd_line, 17'd99999);
         chk("hold_notx", tx_valid, 0);
         @(negedge clk);
      end
      cmd_ready = 1'b1;
      @(negedge clk);
      chk("hold_vfall", cmd_valid, 0);
      chk("hold_keep", cmd_line, 17'd99999);
      ack_expect("hold", 8'h4F, 8'h4B);

      // 4: error lines
      err_case("e_lower", "TFT_c:1,0000", 1'b0);
      err_case("e_dec", "TFT_L:12A45", 1'b0);
      err_case("e_short", "TFT_C:1,123", 1'b0);
      err_case("e_barelf", "", 1'b1);
      send_line("TFT_C:4,DE72");
      check_cmd("after_err", 2'd1, 4'h4, 16'hDE72, 17'd0, 1'b0);

      // 5: bytes during a stalled ACK are dropped
      chk("ovr_pre", rx_overrun, 0);
      tx_ready = 1'b0;
      send_line("TFT_C");
      chk("st_valid", cmd_valid, 1);
      @(negedge clk);
      for (int i = 0; i < 16; i++) send_byte((i < 10) ? (8'h30 + 8'(i)) : (8'h37 + 8'(i)));
      chk("st_txv", tx_valid, 1);
      chk("st_txd", tx_data, 8'h4F);
      chk("st_ovr", rx_overrun, 1);
      tx_ready = 1'b1;
      ack_expect("stall", 8'h4F, 8'h4B);
      send_line("TFT_C");
      check_cmd("post_ovr", 2'd0, 4'h0, 16'h0, 17'd0, 1'b0);
      chk("ovr_sticky", rx_overrun, 1);

      // 6a: reset mid-command
      send_str("TFT_C:A,2C");
      nrst = 1'b0;
      #1;
      check_reset_vals("rst_mid");
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);

      // 6b: reset during the K byte of the acknowledgement
      send_line("TFT_C:A,2C1F");
      chk("rk_valid", cmd_valid, 1);
      chk("rk_col", cmd_color, 16'h2C1F);
      @(negedge clk);
      chk("rk_o", tx_data, 8'h4F);
      @(negedge clk);
      chk("rk_k", tx_data, 8'h4B);
      nrst = 1'b0;
      #1;
      check_reset_vals("rst_ack");
      @(negedge clk);
      nrst = 1'b1;
      base_tx = tx_hs;
      repeat (4) @(negedge clk);
      chk("rk_noack", tx_hs - base_tx, 0);
      send_line("TFT_L:00007");
      check_cmd("post_rst", 2'd2, 4'h0, 16'h0, 17'd7, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
